// File: rtl/tt_sweep_pkg.sv
// Shared types and helpers for the truth-table sweeper.
// Holds the FSM state encodings and the table-width helper.
package tt_sweep_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_SETTLE = ST_SETTLE,
        S_SAMPLE = ST_SAMPLE,
        S_DONE   = ST_DONE
    } sweep_state_e;

    function automatic int tt_w(input int n_in);
        return 1 << n_in;
    endfunction

endpackage

// File: rtl/sweep_settle_timer.sv
// Settle-time down-counter for the sweeper.
// Ports: clk, rst_n, load (reload SETTLE-1), en (count down), expired (count==0).
module sweep_settle_timer #(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(SETTLE - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = RELOAD;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Clocked sequencer that walks every input pattern of a combinational DUT,
// holds each for SETTLE clocks, captures y into a truth table and compares
// it against EXPECTED.
// Ports: clk, rst_n, start, abort in; dut_in out / dut_y in to the DUT;
// busy, done, pass status; table_out, mismatch_cnt, first_fail_* results.
module truth_table_sweeper
    import tt_sweep_pkg::*;
#(
    parameter int                            N_IN     = 4,
    parameter int                            SETTLE   = 2,
    parameter logic [(1 << N_IN)-1:0]        EXPECTED = 16'hF888
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    output logic [N_IN-1:0]        dut_in,
    input  logic                   dut_y,
    output logic                   busy,
    output logic                   done,
    output logic [tt_w(N_IN)-1:0]  table_out,
    output logic [N_IN:0]          mismatch_cnt,
    output logic [N_IN-1:0]        first_fail_idx,
    output logic                   first_fail_vld,
    output logic                   pass
);

    localparam int TT_W = tt_w(N_IN);
    localparam logic [N_IN-1:0] LAST = N_IN'(TT_W - 1);

    sweep_state_e    state_q, state_d;
    logic [N_IN-1:0] dut_in_q, dut_in_d;
    logic [TT_W-1:0] table_q, table_d;
    logic [N_IN:0]   mis_q, mis_d;
    logic [N_IN-1:0] ffi_q, ffi_d;
    logic            ffv_q, ffv_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;

    logic tmr_load;
    logic tmr_en;
    logic tmr_expired;

    sweep_settle_timer #(
        .SETTLE (SETTLE)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (tmr_load),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    assign tmr_en = (state_q == S_SETTLE);

    always_comb begin
        state_d  = state_q;
        dut_in_d = dut_in_q;
        table_d  = table_q;
        mis_d    = mis_q;
        ffi_d    = ffi_q;
        ffv_d    = ffv_q;
        tmr_load = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                // abort has priority over start so a combined
                // request never launches a sweep.
                if (abort) begin
                    state_d  = S_IDLE;
                    dut_in_d = '0;
                end else if (start) begin
                    table_d  = '0;
                    mis_d    = '0;
                    ffi_d    = '0;
                    ffv_d    = 1'b0;
                    dut_in_d = '0;
                    tmr_load = 1'b1;
                    state_d  = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    state_d  = S_IDLE;
                    dut_in_d = '0;
                end else if (tmr_expired) begin
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if (abort) begin
                    state_d  = S_IDLE;
                    dut_in_d = '0;
                end else begin
                    table_d[dut_in_q] = dut_y;
                    if (dut_y != EXPECTED[dut_in_q]) begin
                        mis_d = mis_q + (N_IN+1)'(1);
                        if (!ffv_q) begin
                            ffi_d = dut_in_q;
                            ffv_d = 1'b1;
                        end
                    end
                    if (dut_in_q == LAST) begin
                        state_d = S_DONE;
                    end else begin
                        dut_in_d = dut_in_q + N_IN'(1);
                        tmr_load = 1'b1;
                        state_d  = S_SETTLE;
                    end
                end
            end
            default: begin
                state_d  = S_IDLE;
                dut_in_d = '0;
            end
        endcase

        busy_d = (state_d == S_SETTLE) || (state_d == S_SAMPLE);
        done_d = (state_d == S_DONE);
        pass_d = done_d && (mis_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            dut_in_q <= '0;
            table_q  <= '0;
            mis_q    <= '0;
            ffi_q    <= '0;
            ffv_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dut_in_q <= dut_in_d;
            table_q  <= table_d;
            mis_q    <= mis_d;
            ffi_q    <= ffi_d;
            ffv_q    <= ffv_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
        end
    end

    assign dut_in         = dut_in_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign table_out      = table_q;
    assign mismatch_cnt   = mis_q;
    assign first_fail_idx = ffi_q;
    assign first_fail_vld = ffv_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper with a (a&b)|(c&d) stub DUT.
// Stub faults are injected per pattern through flip_mask.
module tb_truth_table_sweeper;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [3:0]  dut_in;
    logic        dut_y;
    logic        busy;
    logic        done;
    logic [15:0] table_out;
    logic [4:0]  mismatch_cnt;
    logic [3:0]  first_fail_idx;
    logic        first_fail_vld;
    logic        pass;
    logic [15:0] flip_mask = '0;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    assign dut_y = ((dut_in[3] & dut_in[2]) | (dut_in[1] & dut_in[0]))
                   ^ flip_mask[dut_in];

    truth_table_sweeper #(
        .N_IN     (4),
        .SETTLE   (2),
        .EXPECTED (16'hF888)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .dut_in         (dut_in),
        .dut_y          (dut_y),
        .busy           (busy),
        .done           (done),
        .table_out      (table_out),
        .mismatch_cnt   (mismatch_cnt),
        .first_fail_idx (first_fail_idx),
        .first_fail_vld (first_fail_vld),
        .pass           (pass)
    );

    typedef struct {
        logic [15:0] flip;
        logic [15:0] tbl;
        int          cnt;
        int          idx;
        bit          vld;
        bit          pss;
    } vec_t;

    vec_t vecs[5];
    vec_t exp_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " outs"},
            {busy, done, pass, first_fail_vld, dut_in, first_fail_idx,
             mismatch_cnt, 16'(0)},
            32'h0);
        chk({tag, " table"}, 32'(table_out), 32'h0);
    endtask

    // Pop the oldest expected result and compare against the DUT outputs.
    task automatic check_result(input string tag);
        vec_t e;
        if (exp_q.size() == 0) begin
            chk({tag, " scoreboard empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, " done"}, 32'(done), 32'd1);
            chk({tag, " table"}, 32'(table_out), 32'(e.tbl));
            chk({tag, " mcnt"}, 32'(mismatch_cnt), 32'(e.cnt));
            chk({tag, " ffvld"}, 32'(first_fail_vld), 32'(e.vld));
            if (e.vld)
                chk({tag, " ffidx"}, 32'(first_fail_idx), 32'(e.idx));
            chk({tag, " pass"}, 32'(pass), 32'(e.pss));
            chk({tag, " dut_in"}, 32'(dut_in), 32'd15);
        end
    endtask

    // Wait for done after the accepting edge; checks timing and pattern order.
    task automatic wait_done(input string tag);
        int n = 0;
        int bad_busy = 0;
        int bad_seq = 0;
        logic [3:0] prev = 4'd0;
        chk({tag, " first pattern"}, 32'(dut_in), 32'd0);
        while (!done && n < 200) begin
            if (!busy) bad_busy++;
            if (dut_in != prev && dut_in != prev + 4'd1) bad_seq++;
            prev = dut_in;
            tick();
            n++;
        end
        chk({tag, " latency"}, 32'(n), 32'd48);
        chk({tag, " busy during"}, 32'(bad_busy), 32'd0);
        chk({tag, " order"}, 32'(bad_seq), 32'd0);
        chk({tag, " busy after"}, 32'(busy), 32'd0);
    endtask

    task automatic run_sweep(input vec_t v, input string tag);
        flip_mask = v.flip;
        exp_q.push_back(v);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(tag);
        check_result(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        vecs[0] = '{16'h0000, 16'hF888, 0, 0, 1'b0, 1'b1};
        vecs[1] = '{16'h0220, 16'hFAA8, 2, 5, 1'b1, 1'b0};
        vecs[2] = '{16'hFFFF, 16'h0777, 16, 0, 1'b1, 1'b0};
        vecs[3] = '{16'h8000, 16'h7888, 1, 15, 1'b1, 1'b0};
        vecs[4] = '{16'h0001, 16'hF889, 1, 0, 1'b1, 1'b0};

        // Reset and idle for 10 clocks.
        #1;
        chk_zero("async reset");
        do_reset();
        for (int i = 0; i < 10; i++) begin
            chk_zero("idle");
            tick();
        end

        // Table-driven sweeps.
        foreach (vecs[i]) begin
            run_sweep(vecs[i], $sformatf("vec%0d", i));
        end

        // Abort 20 clocks after start.
        flip_mask = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort dut_in", 32'(dut_in), 32'd0);
        chk("abort partial table", 32'(table_out), 32'h0008);
        begin
            int seen = 0;
            for (int i = 0; i < 60; i++) begin
                if (done) seen++;
                tick();
            end
            chk("abort no done", 32'(seen), 32'd0);
        end
        run_sweep(vecs[0], "post abort");

        // Reset at clock 30 of a sweep.
        flip_mask = 16'h0220;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        rst_n = 1'b0;
        #1;
        chk_zero("mid reset");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk_zero("after reset");
        run_sweep(vecs[1], "post reset");

        // start held: back-to-back sweeps with a one-clock done.
        do_reset();
        flip_mask = '0;
        exp_q.push_back(vecs[0]);
        exp_q.push_back(vecs[0]);
        start = 1'b1;
        tick();
        wait_done("held1");
        check_result("held1");
        tick();
        chk("held done drop", 32'(done), 32'd0);
        chk("held restart busy", 32'(busy), 32'd1);
        wait_done("held2");
        start = 1'b0;
        check_result("held2");
        tick();
        chk("held stays done", 32'(done), 32'd1);

        // start+abort together from IDLE.
        do_reset();
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("start+abort busy", 32'(busy), 32'd0);
        tick();
        chk("start+abort idle", 32'({busy, done, dut_in}), 32'd0);

        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
